// File: rtl/pet_io_arbiter_pkg.sv
// ============================================================================
// Module      : pet_io_pkg
// Description : Shared types and constants for the PET I/O window arbiter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package pet_io_pkg;

    localparam int IO_AW  = 8;
    localparam int IO_DW  = 8;
    localparam int WAIT_W = 4;

    localparam logic [WAIT_W-1:0] WAIT_SAT = {WAIT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_HOST_RD = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pet_io_arbiter_if.sv
// ============================================================================
// Module      : pet_io_arbiter_if
// Description : CPU, host and I/O-block signal bundle around the arbiter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface pet_io_arbiter_if;
    import pet_io_pkg::*;

    logic             cpu_cs;
    logic             cpu_we;
    logic [IO_AW-1:0] cpu_addr;
    logic [IO_DW-1:0] cpu_wdata;
    logic [IO_DW-1:0] cpu_rdata;
    logic             cpu_rdy;

    logic             host_req;
    logic             host_we;
    logic [IO_AW-1:0] host_addr;
    logic [IO_DW-1:0] host_wdata;
    logic             host_ack;
    logic [IO_DW-1:0] host_rdata;

    logic             io_cs;
    logic             io_we;
    logic [IO_AW-1:0] io_addr;
    logic [IO_DW-1:0] io_wdata;
    logic [IO_DW-1:0] io_rdata;

    modport slave (
        input  cpu_cs, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_rdy,
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata,
        output io_cs, io_we, io_addr, io_wdata,
        input  io_rdata
    );

    modport master (
        output cpu_cs, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_rdy,
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata,
        input  io_cs, io_we, io_addr, io_wdata,
        output io_rdata
    );

endinterface

`default_nettype wire

// File: rtl/pet_io_arbiter_starve_cnt.sv
// ============================================================================
// Module      : pet_io_starve_cnt
// Description : Saturating count of denied host slots with starvation compare.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pet_io_starve_cnt
    import pet_io_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic i_inc,
    input  wire logic i_clr,
    output logic      o_starve
);

    localparam logic [WAIT_W-1:0] C_MAX_WAIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != WAIT_SAT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // MAX_WAIT of zero makes this permanently true: host wins every eligible slot.
    assign o_starve = (r_cnt >= C_MAX_WAIT);

endmodule

`default_nettype wire

// File: rtl/pet_io_arbiter.sv
// ============================================================================
// Module      : pet_io_arbiter
// Description : Shares the PET I/O register window between CPU and host master.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pet_io_arbiter
    import pet_io_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    input  wire logic        ce,
    pet_io_arbiter_if.slave  bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_host_ack;
    logic             w_host_ack_nxt;
    logic [IO_DW-1:0] r_host_rdata;
    logic [IO_DW-1:0] w_host_rdata_nxt;

    logic             w_starve;
    logic             w_eligible;
    logic             w_sel_host;
    logic             w_cnt_inc;
    logic             w_cnt_clr;

    // Reset gating keeps the window on the CPU mux while reset_n is low.
    assign w_eligible = reset_n & ce & bus.host_req & (r_state == ST_IDLE) & ~r_host_ack;
    assign w_sel_host = w_eligible & (~bus.cpu_cs | w_starve);
    assign w_cnt_inc  = w_eligible & ~w_sel_host;
    assign w_cnt_clr  = w_sel_host | ~bus.host_req;

    pet_io_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_inc    (w_cnt_inc),
        .i_clr    (w_cnt_clr),
        .o_starve (w_starve)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_host_ack   <= 1'b0;
            r_host_rdata <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_host_ack   <= w_host_ack_nxt;
            r_host_rdata <= w_host_rdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_host_ack_nxt   = 1'b0;
        w_host_rdata_nxt = r_host_rdata;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_host) begin
                    if (bus.host_we) begin
                        w_host_ack_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_HOST_RD;
                    end
                end
            end
            ST_HOST_RD: begin
                // I/O block registers its read mux, so data is valid one clock after the slot.
                w_host_ack_nxt   = 1'b1;
                w_host_rdata_nxt = bus.io_rdata;
                w_state_nxt      = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.io_cs      = w_sel_host ? 1'b1           : bus.cpu_cs;
    assign bus.io_we      = w_sel_host ? bus.host_we    : bus.cpu_we;
    assign bus.io_addr    = w_sel_host ? bus.host_addr  : bus.cpu_addr;
    assign bus.io_wdata   = w_sel_host ? bus.host_wdata : bus.cpu_wdata;

    assign bus.cpu_rdy    = ~(w_sel_host & bus.cpu_cs);
    assign bus.cpu_rdata  = bus.io_rdata;
    assign bus.host_ack   = r_host_ack;
    assign bus.host_rdata = r_host_rdata;

endmodule

`default_nettype wire

// File: tb/tb_pet_io_arbiter.sv
// ============================================================================
// Module      : tb_pet_io_arbiter
// Description : Directed vectors plus randomized run against a slot-level model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pet_io_arbiter;

    typedef struct {
        logic       rst_n, ce, cpu_cs, cpu_we;
        logic [7:0] cpu_addr, cpu_wdata;
        logic       host_req, host_we;
        logic [7:0] host_addr, host_wdata, io_rdata;
        logic       e_io_cs, e_io_we;
        logic [7:0] e_io_addr, e_io_wdata;
        logic       e_rdy, e_ack;
        logic [7:0] e_hrdata;
    } vec_t;

    logic       clk = 1'b0;
    logic       t_rst_n = 1'b0, t_ce = 1'b0, t_cpu_cs = 1'b0, t_cpu_we = 1'b0;
    logic       t_host_req = 1'b0, t_host_we = 1'b0;
    logic [7:0] t_cpu_addr = '0, t_cpu_wdata = '0, t_host_addr = '0, t_host_wdata = '0, t_io_rdata = '0;

    logic       d_io_cs[2], d_io_we[2], d_rdy[2], d_ack[2];
    logic [7:0] d_io_addr[2], d_io_wdata[2], d_cpu_rdata[2], d_hrdata[2];

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: index 0 is the MAX_WAIT=4 instance, index 1 is MAX_WAIT=0.
    int         m_mw[2] = '{4, 0};
    int         m_denied[2];
    bit         m_rd_busy[2], m_ack[2];
    logic [7:0] m_rdata[2];
    bit         model_on = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pet_io_arbiter_if u_bus ();
        assign u_bus.cpu_cs     = t_cpu_cs;
        assign u_bus.cpu_we     = t_cpu_we;
        assign u_bus.cpu_addr   = t_cpu_addr;
        assign u_bus.cpu_wdata  = t_cpu_wdata;
        assign u_bus.host_req   = t_host_req;
        assign u_bus.host_we    = t_host_we;
        assign u_bus.host_addr  = t_host_addr;
        assign u_bus.host_wdata = t_host_wdata;
        assign u_bus.io_rdata   = t_io_rdata;
        assign d_io_cs[g]       = u_bus.io_cs;
        assign d_io_we[g]       = u_bus.io_we;
        assign d_io_addr[g]     = u_bus.io_addr;
        assign d_io_wdata[g]    = u_bus.io_wdata;
        assign d_rdy[g]         = u_bus.cpu_rdy;
        assign d_ack[g]         = u_bus.host_ack;
        assign d_hrdata[g]      = u_bus.host_rdata;
        assign d_cpu_rdata[g]   = u_bus.cpu_rdata;

        pet_io_arbiter #(.MAX_WAIT((g == 0) ? 4 : 0)) u_dut (
            .clk     (clk),
            .reset_n (t_rst_n),
            .ce      (t_ce),
            .bus     (u_bus.slave)
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic vec_t V(input logic rst_n, ce, cpu_cs, cpu_we, input logic [7:0] ca, cwd,
                               input logic hr, hw, input logic [7:0] ha, hwd, iord,
                               input logic eio_cs, eio_we, input logic [7:0] ea, ewd,
                               input logic erdy, eack, input logic [7:0] erd);
        vec_t v;
        v.rst_n = rst_n; v.ce = ce; v.cpu_cs = cpu_cs; v.cpu_we = cpu_we;
        v.cpu_addr = ca; v.cpu_wdata = cwd; v.host_req = hr; v.host_we = hw;
        v.host_addr = ha; v.host_wdata = hwd; v.io_rdata = iord;
        v.e_io_cs = eio_cs; v.e_io_we = eio_we; v.e_io_addr = ea; v.e_io_wdata = ewd;
        v.e_rdy = erdy; v.e_ack = eack; v.e_hrdata = erd;
        return v;
    endfunction

    function automatic bit m_grant(input int k);
        return t_rst_n && t_ce && t_host_req && !m_rd_busy[k] && !m_ack[k]
               && (!t_cpu_cs || (m_denied[k] >= m_mw[k]));
    endfunction

    task automatic m_update(input int k);
        bit g, was_rd, was_ack;
        g       = m_grant(k);
        was_rd  = m_rd_busy[k];
        was_ack = m_ack[k];
        if (!t_rst_n) begin
            m_denied[k] = 0; m_rd_busy[k] = 0; m_ack[k] = 0; m_rdata[k] = 8'h00;
        end else begin
            if (was_rd) m_rdata[k] = t_io_rdata;
            m_ack[k]     = was_rd || (g && t_host_we);
            m_rd_busy[k] = g && !t_host_we;
            if (g || !t_host_req)                   m_denied[k] = 0;
            else if (t_ce && !was_rd && !was_ack)   m_denied[k]++;
        end
    endtask

    task automatic m_check(input int k);
        bit g;
        g = m_grant(k);
        chk($sformatf("m%0d io_cs", k),     32'(d_io_cs[k]),     32'(g ? 1'b1 : t_cpu_cs));
        chk($sformatf("m%0d io_we", k),     32'(d_io_we[k]),     32'(g ? t_host_we : t_cpu_we));
        chk($sformatf("m%0d io_addr", k),   32'(d_io_addr[k]),   32'(g ? t_host_addr : t_cpu_addr));
        chk($sformatf("m%0d io_wdata", k),  32'(d_io_wdata[k]),  32'(g ? t_host_wdata : t_cpu_wdata));
        chk($sformatf("m%0d cpu_rdy", k),   32'(d_rdy[k]),       32'(!(g && t_cpu_cs)));
        chk($sformatf("m%0d host_ack", k),  32'(d_ack[k]),       32'(m_ack[k]));
        chk($sformatf("m%0d host_rdata", k),32'(d_hrdata[k]),    32'(m_rdata[k]));
        chk($sformatf("m%0d cpu_rdata", k), 32'(d_cpu_rdata[k]), 32'(t_io_rdata));
    endtask

    // Drive one cycle's inputs, compare at the falling edge, advance the model at the rising edge.
    task automatic run(input vec_t v, input int k, input bit do_chk, input string tag);
        t_rst_n = v.rst_n; t_ce = v.ce; t_cpu_cs = v.cpu_cs; t_cpu_we = v.cpu_we;
        t_cpu_addr = v.cpu_addr; t_cpu_wdata = v.cpu_wdata; t_host_req = v.host_req;
        t_host_we = v.host_we; t_host_addr = v.host_addr; t_host_wdata = v.host_wdata;
        t_io_rdata = v.io_rdata;
        @(negedge clk);
        if (do_chk) begin
            chk({tag, " io_cs"},      32'(d_io_cs[k]),    32'(v.e_io_cs));
            chk({tag, " io_we"},      32'(d_io_we[k]),    32'(v.e_io_we));
            chk({tag, " io_addr"},    32'(d_io_addr[k]),  32'(v.e_io_addr));
            chk({tag, " io_wdata"},   32'(d_io_wdata[k]), 32'(v.e_io_wdata));
            chk({tag, " cpu_rdy"},    32'(d_rdy[k]),      32'(v.e_rdy));
            chk({tag, " host_ack"},   32'(d_ack[k]),      32'(v.e_ack));
            chk({tag, " host_rdata"}, 32'(d_hrdata[k]),   32'(v.e_hrdata));
        end
        if (model_on) begin
            m_check(0);
            m_check(1);
        end
        @(posedge clk);
        m_update(0);
        m_update(1);
        #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++)
            run(V(0,1,0,0,8'h00,8'h00,0,0,8'h00,8'h00,8'h00, 0,0,8'h00,8'h00,1,0,8'h00), 0, 1'b0, "rst");
    endtask

    vec_t vt[$];
    vec_t hs[$];

    initial begin
        // rst ce cs we caddr cwd  req hwe haddr hwd  iord   e_cs e_we e_addr e_wd rdy ack hrd
        vt.push_back(V(0,1,0,0,8'h07,8'h00, 1,1,8'h99,8'h66,8'h00, 0,0,8'h07,8'h00,1,0,8'h00));
        vt.push_back(V(1,1,0,0,8'h07,8'h00, 1,1,8'h12,8'h3C,8'h00, 1,1,8'h12,8'h3C,1,0,8'h00));
        vt.push_back(V(1,1,0,0,8'h07,8'h00, 1,1,8'h12,8'h3C,8'h00, 0,0,8'h07,8'h00,1,1,8'h00));
        vt.push_back(V(1,1,0,0,8'h07,8'h00, 1,0,8'h40,8'h00,8'h00, 1,0,8'h40,8'h00,1,0,8'h00));
        vt.push_back(V(1,1,1,1,8'h21,8'h11, 1,0,8'h40,8'h00,8'hA5, 1,1,8'h21,8'h11,1,0,8'h00));
        vt.push_back(V(1,1,1,1,8'h21,8'h11, 0,0,8'h40,8'h00,8'h00, 1,1,8'h21,8'h11,1,1,8'hA5));
        vt.push_back(V(1,1,0,0,8'h07,8'h00, 0,0,8'h00,8'h00,8'h00, 0,0,8'h07,8'h00,1,0,8'hA5));
        // CPU busy every slot: four denials (one ce=0 gap in between), then the host steals slot five.
        vt.push_back(V(1,1,1,0,8'h01,8'h00, 1,1,8'h30,8'h5A,8'h00, 1,0,8'h01,8'h00,1,0,8'hA5));
        vt.push_back(V(1,0,1,0,8'h01,8'h00, 1,1,8'h30,8'h5A,8'h00, 1,0,8'h01,8'h00,1,0,8'hA5));
        for (int i = 0; i < 3; i++)
            vt.push_back(V(1,1,1,0,8'h01,8'h00, 1,1,8'h30,8'h5A,8'h00, 1,0,8'h01,8'h00,1,0,8'hA5));
        vt.push_back(V(1,1,1,0,8'h01,8'h00, 1,1,8'h30,8'h5A,8'h00, 1,1,8'h30,8'h5A,0,0,8'hA5));
        vt.push_back(V(1,1,1,0,8'h01,8'h00, 0,0,8'h30,8'h5A,8'h00, 1,0,8'h01,8'h00,1,1,8'hA5));
        vt.push_back(V(1,1,1,0,8'h01,8'h00, 0,0,8'h30,8'h5A,8'h00, 1,0,8'h01,8'h00,1,0,8'hA5));
        // Request withdrawn after two denials: no access, no ack, and the count starts over.
        for (int i = 0; i < 2; i++)
            vt.push_back(V(1,1,1,0,8'h01,8'h00, 1,1,8'h30,8'h5A,8'h00, 1,0,8'h01,8'h00,1,0,8'hA5));
        for (int i = 0; i < 2; i++)
            vt.push_back(V(1,1,1,0,8'h01,8'h00, 0,1,8'h30,8'h5A,8'h00, 1,0,8'h01,8'h00,1,0,8'hA5));
        for (int i = 0; i < 4; i++)
            vt.push_back(V(1,1,1,0,8'h01,8'h00, 1,1,8'h31,8'h5B,8'h00, 1,0,8'h01,8'h00,1,0,8'hA5));
        vt.push_back(V(1,1,1,0,8'h01,8'h00, 1,1,8'h31,8'h5B,8'h00, 1,1,8'h31,8'h5B,0,0,8'hA5));
        vt.push_back(V(1,1,1,0,8'h01,8'h00, 0,0,8'h31,8'h5B,8'h00, 1,0,8'h01,8'h00,1,1,8'hA5));

        do_reset();
        for (int i = 0; i < vt.size(); i++)
            run(vt[i], 0, 1'b1, $sformatf("row%0d", i));

        // Reset arriving while a host read sits in its capture cycle.
        hs.push_back(V(1,1,0,0,8'h07,8'h00, 1,0,8'h40,8'h00,8'h00, 1,0,8'h40,8'h00,1,0,8'hA5));
        hs.push_back(V(0,1,1,0,8'h2B,8'h00, 1,0,8'h40,8'h00,8'hEE, 1,0,8'h2B,8'h00,1,0,8'hA5));
        hs.push_back(V(1,1,0,0,8'h07,8'h00, 0,0,8'h40,8'h00,8'h00, 0,0,8'h07,8'h00,1,0,8'h00));
        hs.push_back(V(1,1,0,0,8'h07,8'h00, 1,1,8'h5C,8'h42,8'h00, 1,1,8'h5C,8'h42,1,0,8'h00));
        hs.push_back(V(1,1,0,0,8'h07,8'h00, 0,0,8'h5C,8'h42,8'h00, 0,0,8'h07,8'h00,1,1,8'h00));
        for (int i = 0; i < hs.size(); i++)
            run(hs[i], 0, 1'b1, $sformatf("rsthd%0d", i));

        // MAX_WAIT=0 instance: host wins a contested slot, CPU retries next slot.
        do_reset();
        hs.delete();
        hs.push_back(V(1,1,1,1,8'h10,8'h77, 1,1,8'h20,8'h88,8'h00, 1,1,8'h20,8'h88,0,0,8'h00));
        hs.push_back(V(1,1,1,1,8'h10,8'h77, 0,0,8'h20,8'h88,8'h00, 1,1,8'h10,8'h77,1,1,8'h00));
        hs.push_back(V(1,1,0,0,8'h10,8'h00, 1,0,8'h44,8'h00,8'h00, 1,0,8'h44,8'h00,1,0,8'h00));
        hs.push_back(V(1,1,1,0,8'h10,8'h00, 0,0,8'h44,8'h00,8'h3D, 1,0,8'h10,8'h00,1,0,8'h00));
        hs.push_back(V(1,1,1,0,8'h10,8'h00, 0,0,8'h44,8'h00,8'h00, 1,0,8'h10,8'h00,1,1,8'h3D));
        for (int i = 0; i < hs.size(); i++)
            run(hs[i], 1, 1'b1, $sformatf("mw0_%0d", i));

        model_on = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            vec_t r;
            r = V($urandom_range(0, 63) != 0, $urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom),
                  8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0, 1'($urandom),
                  8'($urandom), 8'($urandom), 8'($urandom), 0,0,8'h00,8'h00,0,0,8'h00);
            run(r, 0, 1'b0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
